// File: rtl/fp_align_if.sv
// Operand/result handshake bundle for fp_align: the operand pair in, the aligned pair out.
interface fp_align_if #(
    parameter int unsigned SIG_W = 22,
    parameter int unsigned EXP_W = 5
) ();
    logic             in_valid;
    logic             in_ready;
    logic [SIG_W-1:0] a_sig;
    logic [SIG_W-1:0] b_sig;
    logic [EXP_W-1:0] a_exp;
    logic [EXP_W-1:0] b_exp;
    logic             a_sign;
    logic             b_sign;
    logic             out_valid;
    logic             out_ready;
    logic [SIG_W-1:0] big_sig;
    logic [SIG_W-1:0] small_sig;
    logic             big_sign;
    logic             small_sign;
    logic [EXP_W-1:0] exp_out;
    logic             sticky;
    logic             swapped;

    modport slave (
        input  in_valid, a_sig, b_sig, a_exp, b_exp, a_sign, b_sign, out_ready,
        output in_ready, out_valid, big_sig, small_sig, big_sign, small_sign, exp_out, sticky,
               swapped
    );

    modport master (
        output in_valid, a_sig, b_sig, a_exp, b_exp, a_sign, b_sign, out_ready,
        input  in_ready, out_valid, big_sig, small_sig, big_sign, small_sign, exp_out, sticky,
               swapped
    );
endinterface

// File: rtl/fp_align.sv
// Floating-point operand aligner: swaps so the larger exponent is "big", then shifts the
// smaller significand right one bit per cycle. Macro FP_ALIGN_STICKY_EN enables sticky tracking.
module fp_align #(
    parameter int unsigned SIG_W = 22,
    parameter int unsigned EXP_W = 5
) (
    input logic       clk,
    input logic       rst,
    fp_align_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           r_state, w_state_nxt;
    logic [SIG_W-1:0] r_big_sig, w_big_sig_nxt;
    logic [SIG_W-1:0] r_small_sig, w_small_sig_nxt;
    logic             r_big_sign, w_big_sign_nxt;
    logic             r_small_sign, w_small_sign_nxt;
    logic [EXP_W-1:0] r_exp, w_exp_nxt;
    logic             r_sticky, w_sticky_nxt;
    logic             r_swapped, w_swapped_nxt;
    logic [EXP_W-1:0] r_cnt, w_cnt_nxt;

    logic             w_swap;
    logic [EXP_W-1:0] w_hi_exp;
    logic [EXP_W-1:0] w_lo_exp;
    logic [EXP_W-1:0] w_diff;
    logic             w_diff_big;
    logic [SIG_W-1:0] w_cap_small;
    logic             w_cap_or;
    logic             w_lsb_out;

    assign w_swap      = bus.b_exp > bus.a_exp;
    assign w_hi_exp    = w_swap ? bus.b_exp : bus.a_exp;
    assign w_lo_exp    = w_swap ? bus.a_exp : bus.b_exp;
    assign w_diff      = w_hi_exp - w_lo_exp;
    assign w_diff_big  = 32'(w_diff) > SIG_W;
    assign w_cap_small = w_swap ? bus.a_sig : bus.b_sig;

`ifdef FP_ALIGN_STICKY_EN
    assign w_cap_or  = |w_cap_small;
    assign w_lsb_out = r_small_sig[0];
`else
    // Shifted-out bits are simply dropped; sticky register stays at its reset value.
    assign w_cap_or  = 1'b0;
    assign w_lsb_out = 1'b0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_big_sig_nxt    = r_big_sig;
        w_small_sig_nxt  = r_small_sig;
        w_big_sign_nxt   = r_big_sign;
        w_small_sign_nxt = r_small_sign;
        w_exp_nxt        = r_exp;
        w_sticky_nxt     = r_sticky;
        w_swapped_nxt    = r_swapped;
        w_cnt_nxt        = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (bus.in_valid) begin
                    w_big_sig_nxt    = w_swap ? bus.b_sig : bus.a_sig;
                    w_big_sign_nxt   = w_swap ? bus.b_sign : bus.a_sign;
                    w_small_sign_nxt = w_swap ? bus.a_sign : bus.b_sign;
                    w_exp_nxt        = w_hi_exp;
                    w_swapped_nxt    = w_swap;
                    w_small_sig_nxt  = w_cap_small;
                    w_sticky_nxt     = 1'b0;
                    w_cnt_nxt        = '0;
                    if (w_diff == '0) begin
                        w_state_nxt = StDone;
                    end else if (w_diff_big) begin
                        // Everything would be shifted out: skip the walk.
                        w_small_sig_nxt = '0;
                        w_sticky_nxt    = w_cap_or;
                        w_state_nxt     = StDone;
                    end else begin
                        w_cnt_nxt   = w_diff;
                        w_state_nxt = StShift;
                    end
                end
            end
            StShift: begin
                w_small_sig_nxt = r_small_sig >> 1;
                w_sticky_nxt    = r_sticky | w_lsb_out;
                w_cnt_nxt       = r_cnt - EXP_W'(1);
                if (r_cnt == EXP_W'(1)) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_big_sig    <= '0;
            r_small_sig  <= '0;
            r_big_sign   <= 1'b0;
            r_small_sign <= 1'b0;
            r_exp        <= '0;
            r_sticky     <= 1'b0;
            r_swapped    <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_big_sig    <= w_big_sig_nxt;
            r_small_sig  <= w_small_sig_nxt;
            r_big_sign   <= w_big_sign_nxt;
            r_small_sign <= w_small_sign_nxt;
            r_exp        <= w_exp_nxt;
            r_sticky     <= w_sticky_nxt;
            r_swapped    <= w_swapped_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    // Handshake flags are masked while reset is held so nothing is advertised mid-reset.
    assign bus.in_ready   = (r_state == StIdle) && !rst;
    assign bus.out_valid  = (r_state == StDone) && !rst;
    assign bus.big_sig    = r_big_sig;
    assign bus.small_sig  = r_small_sig;
    assign bus.big_sign   = r_big_sign;
    assign bus.small_sign = r_small_sign;
    assign bus.exp_out    = r_exp;
    assign bus.sticky     = r_sticky;
    assign bus.swapped    = r_swapped;
endmodule

// File: doc/fp_align.md
FP_ALIGN -- requirements
Module: fp_align

Interface
REQ-001 The module SHALL have parameter SIG_W, default 22, significand width.
REQ-002 The module SHALL have parameter EXP_W, default 5, biased exponent width.
REQ-003 The module SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand pair present.
REQ-007 in_ready  output  1  block can accept an operand pair.
REQ-008 a_sig, b_sig  input  SIG_W  operand significands.
REQ-009 a_exp, b_exp  input  EXP_W  operand exponents.
REQ-010 a_sign, b_sign  input  1  operand signs.
REQ-011 out_valid  output  1  aligned result present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 big_sig, small_sig  output  SIG_W  larger-exponent significand; right-shifted smaller-exponent significand.
REQ-014 big_sign, small_sign  output  1  signs following the operand swap.
REQ-015 exp_out  output  EXP_W  common exponent, equal to max(a_exp, b_exp).
REQ-016 sticky  output  1  OR of all bits shifted out of small_sig.
REQ-017 swapped  output  1  high when b_exp > a_exp, meaning big is operand b.

Function
REQ-018 FSM SHALL have three states: IDLE, SHIFT, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-019 Transfer in IDLE with in_valid=1 SHALL capture operands and select big = larger exponent; on equal exponents big = a and swapped = 0.
REQ-020 On capture the exponent difference d SHALL be computed as an unsigned EXP_W-bit value, always non-negative after the swap.
REQ-021 If d=0, next state SHALL be DONE with small_sig unshifted and sticky=0.
REQ-022 If 1 <= d <= SIG_W, next state SHALL be SHIFT, with a down-counter loaded with d.
REQ-023 Each SHIFT cycle SHALL shift small_sig right by 1 with zero fill, OR the shifted-out LSB into sticky, and decrement the counter.
REQ-024 SHIFT SHALL go to DONE in the cycle the counter reaches 0, so out_valid rises d+1 cycles after the accepting edge.
REQ-025 If d > SIG_W, next state SHALL be DONE directly, with small_sig=0 and sticky = OR of the captured small significand, so latency is 1 cycle.
REQ-026 In DONE, all outputs SHALL hold stable while out_ready=0; a transfer with out_ready=1 SHALL return the FSM to IDLE on that edge.
REQ-027 No new operand SHALL be accepted in the cycle a result is transferred; in_ready rises the following cycle.
REQ-028 in_valid seen outside IDLE SHALL be ignored, and captured operands SHALL never change during SHIFT or DONE.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE from any state, discarding any operation in progress.
REQ-030 On rst, every output data register (big_sig, small_sig, big_sign, small_sign, exp_out, sticky, swapped) and the counter SHALL be cleared to 0.
REQ-031 While in reset, out_valid SHALL be 0, and in_ready SHALL be 1 from the first cycle after rst deasserts.

Configuration
REQ-032 Macro FP_ALIGN_STICKY_EN SHALL control the sticky logic.
REQ-033 With FP_ALIGN_STICKY_EN defined, sticky SHALL behave per REQ-023 and REQ-025.
REQ-034 Without FP_ALIGN_STICKY_EN, sticky SHALL be constant 0, shifted-out bits SHALL be discarded, and all other behaviour and latency SHALL be unchanged.

Verification
REQ-035 a_exp=10, b_exp=7, b_sig=0x100005 -> out_valid 4 cycles after accept; small_sig=0x020000; sticky=1; swapped=0; exp_out=10.
REQ-036 a_exp=b_exp=5, a_sig=0x200000, b_sig=0x2AAAAA -> out_valid 1 cycle after accept; big_sig=0x200000; small_sig=0x2AAAAA; sticky=0; swapped=0.
REQ-037 a_exp=0, b_exp=30, a_sig=0x3FFFFF -> out_valid 1 cycle after accept; small_sig=0; sticky=1; swapped=1; exp_out=30; big_sign=b_sign.
REQ-038 Result in DONE with out_ready=0 for 5 cycles -> outputs constant, in_ready=0; then out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-039 rst=1 in the second SHIFT cycle of a d=6 operation -> next cycle IDLE, out_valid=0, all outputs 0, in_ready=1 after rst drops.
REQ-040 Rerun REQ-035 without FP_ALIGN_STICKY_EN -> same small_sig and latency, sticky=0.
